// File: rtl/cbfp1_norm_shift.sv
// CBFP stage-1 normaliser: aligns butterfly data with the block-minimum
// LZCs, shifts each group left, keeps the top bits and counts blocks.
// Optional build macro: CBFP1_ROUND_EN (round half-up with positive saturation).
module cbfp1_norm_shift #(
    parameter int IN_WIDTH      = 23,
    parameter int OUT_WIDTH     = 11,
    parameter int LZC_WIDTH     = 5,
    parameter int MIN_LAT       = 2,
    parameter int BLK_PER_FRAME = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 valid_in,
    input  logic [IN_WIDTH-1:0]  din_R_add  [0:7],
    input  logic [IN_WIDTH-1:0]  din_Q_add  [0:7],
    input  logic [IN_WIDTH-1:0]  din_R_sub  [0:7],
    input  logic [IN_WIDTH-1:0]  din_Q_sub  [0:7],
    input  logic [LZC_WIDTH-1:0] min_add,
    input  logic [LZC_WIDTH-1:0] min_sub,
    output logic [OUT_WIDTH-1:0] dout_R_add [0:7],
    output logic [OUT_WIDTH-1:0] dout_Q_add [0:7],
    output logic [OUT_WIDTH-1:0] dout_R_sub [0:7],
    output logic [OUT_WIDTH-1:0] dout_Q_sub [0:7],
    output logic [LZC_WIDTH-1:0] index_add,
    output logic [LZC_WIDTH-1:0] index_sub,
    output logic                 valid_out,
    output logic                 frame_last
);

    localparam int CW = (BLK_PER_FRAME > 1) ? $clog2(BLK_PER_FRAME) : 1;
    localparam logic [LZC_WIDTH-1:0] SH_MAX = LZC_WIDTH'(IN_WIDTH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLK_PER_FRAME - 1);
    localparam int LAST = MIN_LAT - 1;

    // path order: 0 = R_add, 1 = Q_add, 2 = R_sub, 3 = Q_sub
    logic [IN_WIDTH-1:0]  din_all [0:3][0:7];
    logic [IN_WIDTH-1:0]  dl      [0:MIN_LAT-1][0:3][0:7];
    logic [MIN_LAT-1:0]   vl;
    logic [OUT_WIDTH-1:0] nrm     [0:3][0:7];
    logic [LZC_WIDTH-1:0] sh_add;
    logic [LZC_WIDTH-1:0] sh_sub;
    logic [CW-1:0]        blk_cnt;

    // Shift one lane and keep the top OUT_WIDTH bits.
    function automatic logic [OUT_WIDTH-1:0] norm(
        input logic [IN_WIDTH-1:0]  x,
        input logic [LZC_WIDTH-1:0] sh
    );
        logic [IN_WIDTH-1:0] tmp;
`ifdef CBFP1_ROUND_EN
        logic [OUT_WIDTH:0] top;
        logic [OUT_WIDTH:0] sum;
`endif
        tmp = x << sh;
`ifdef CBFP1_ROUND_EN
        // top[0] is the first discarded bit; adding it rounds half-up
        top = (OUT_WIDTH+1)'(tmp >> (IN_WIDTH - OUT_WIDTH - 1));
        sum = {top[OUT_WIDTH], top[OUT_WIDTH:1]}
            + {{OUT_WIDTH{1'b0}}, top[0]};
        // adding a non-negative bit can only overflow upward
        if (sum[OUT_WIDTH] != sum[OUT_WIDTH-1])
            return {1'b0, {(OUT_WIDTH-1){1'b1}}};
        return sum[OUT_WIDTH-1:0];
`else
        return OUT_WIDTH'(tmp >> (IN_WIDTH - OUT_WIDTH));
`endif
    endfunction

    // Gather the four lane sets into one array for the delay line.
    always_comb begin
        for (int l = 0; l < 8; l++) begin
            din_all[0][l] = din_R_add[l];
            din_all[1][l] = din_Q_add[l];
            din_all[2][l] = din_R_sub[l];
            din_all[3][l] = din_Q_sub[l];
        end
    end

    // Delay data and valid by MIN_LAT en-cycles to meet the min LZCs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vl <= '0;
            for (int s = 0; s < MIN_LAT; s++)
                for (int p = 0; p < 4; p++)
                    for (int l = 0; l < 8; l++)
                        dl[s][p][l] <= '0;
        end else if (en) begin
            vl[0] <= valid_in;
            for (int s = 1; s < MIN_LAT; s++)
                vl[s] <= vl[s-1];
            for (int p = 0; p < 4; p++)
                for (int l = 0; l < 8; l++) begin
                    dl[0][p][l] <= din_all[p][l];
                    for (int s = 1; s < MIN_LAT; s++)
                        dl[s][p][l] <= dl[s-1][p][l];
                end
        end
    end

    // Clamp each group shift so an all-zero block cannot over-shift.
    always_comb begin
        sh_add = (min_add > SH_MAX) ? SH_MAX : min_add;
        sh_sub = (min_sub > SH_MAX) ? SH_MAX : min_sub;
    end

    // Normalise every lane of the aligned stage; R and Q share a shift.
    always_comb begin
        for (int l = 0; l < 8; l++) begin
            nrm[0][l] = norm(dl[LAST][0][l], sh_add);
            nrm[1][l] = norm(dl[LAST][1][l], sh_add);
            nrm[2][l] = norm(dl[LAST][2][l], sh_sub);
            nrm[3][l] = norm(dl[LAST][3][l], sh_sub);
        end
    end

    // Register results, exponents and the frame position of each block.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out  <= 1'b0;
            frame_last <= 1'b0;
            index_add  <= '0;
            index_sub  <= '0;
            blk_cnt    <= '0;
            for (int l = 0; l < 8; l++) begin
                dout_R_add[l] <= '0;
                dout_Q_add[l] <= '0;
                dout_R_sub[l] <= '0;
                dout_Q_sub[l] <= '0;
            end
        end else if (en) begin
            valid_out  <= vl[LAST];
            frame_last <= vl[LAST] && (blk_cnt == CNT_LAST);
            if (vl[LAST]) begin
                index_add <= sh_add;
                index_sub <= sh_sub;
                blk_cnt   <= (blk_cnt == CNT_LAST) ? '0 : blk_cnt + 1'b1;
                for (int l = 0; l < 8; l++) begin
                    dout_R_add[l] <= nrm[0][l];
                    dout_Q_add[l] <= nrm[1][l];
                    dout_R_sub[l] <= nrm[2][l];
                    dout_Q_sub[l] <= nrm[3][l];
                end
            end
        end
    end

endmodule

// File: tb/tb_cbfp1_norm_shift.sv
// Directed bench for cbfp1_norm_shift (default parameters, MIN_LAT=2).
// Also meant to be built with CBFP1_ROUND_EN defined.
module tb_cbfp1_norm_shift;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b1;
    logic        valid_in = 1'b0;
    logic [22:0] din_R_add [0:7];
    logic [22:0] din_Q_add [0:7];
    logic [22:0] din_R_sub [0:7];
    logic [22:0] din_Q_sub [0:7];
    logic [4:0]  min_add;
    logic [4:0]  min_sub;
    logic [10:0] dout_R_add [0:7];
    logic [10:0] dout_Q_add [0:7];
    logic [10:0] dout_R_sub [0:7];
    logic [10:0] dout_Q_sub [0:7];
    logic [4:0]  index_add;
    logic [4:0]  index_sub;
    logic        valid_out;
    logic        frame_last;

    // upstream min detector model: min arrives MIN_LAT en-cycles after data
    logic [4:0] mnext_add = '0;
    logic [4:0] mnext_sub = '0;
    logic [4:0] mq_a0 = '0, mq_a1 = '0;
    logic [4:0] mq_s0 = '0, mq_s1 = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (en) begin
            mq_a0 <= mnext_add;
            mq_a1 <= mq_a0;
            mq_s0 <= mnext_sub;
            mq_s1 <= mq_s0;
        end
    end

    assign min_add = mq_a1;
    assign min_sub = mq_s1;

    cbfp1_norm_shift dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .valid_in   (valid_in),
        .din_R_add  (din_R_add),
        .din_Q_add  (din_Q_add),
        .din_R_sub  (din_R_sub),
        .din_Q_sub  (din_Q_sub),
        .min_add    (min_add),
        .min_sub    (min_sub),
        .dout_R_add (dout_R_add),
        .dout_Q_add (dout_Q_add),
        .dout_R_sub (dout_R_sub),
        .dout_Q_sub (dout_Q_sub),
        .index_add  (index_add),
        .index_sub  (index_sub),
        .valid_out  (valid_out),
        .frame_last (frame_last)
    );

    task automatic fill_din(input logic [22:0] v);
        for (int i = 0; i < 8; i++) begin
            din_R_add[i] = v;
            din_Q_add[i] = v;
            din_R_sub[i] = v;
            din_Q_sub[i] = v;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        valid_in = 1'b0;
        en = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // present the block currently on din for one cycle, then wait for it
    task automatic send_and_wait(output bit ok);
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (valid_out) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int lat;
        fill_din('0);
        #1;
        checks++;
        if (valid_out !== 1'b0 || dout_R_add[0] !== '0 ||
            index_add !== '0 || frame_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: vo=%b d=%0d idx=%0d fl=%b req 0",
                     valid_out, dout_R_add[0], index_add, frame_last);
        end
        do_reset();
        // stream blocks so some are in flight
        din_R_add[0] = 23'h10000;
        mnext_add = 5'd3;
        valid_in = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (valid_out !== 1'b1 || dout_R_add[0] !== 11'd128 ||
            index_add !== 5'd3) begin
            errors++;
            $display("FAIL pre_reset: vo=%b d=%0d idx=%0d req 1/128/3",
                     valid_out, dout_R_add[0], index_add);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || dout_R_add[0] !== '0 ||
            index_add !== '0 || frame_last !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: vo=%b d=%0d idx=%0d req 0",
                     valid_out, dout_R_add[0], index_add);
        end
        @(negedge clk);
        rstn = 1'b1;
        valid_in = 1'b0;
        lat = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (valid_out) lat++;
        end
        checks++;
        if (lat != 0) begin
            errors++;
            $display("FAIL reset_flush: valid cycles=%0d req 0", lat);
        end
        // latency from a fresh valid_in
        valid_in = 1'b1;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            valid_in = 1'b0;
            if (valid_out && lat == 0) lat = n;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL latency: got=%0d req 3", lat);
        end
        mnext_add = '0;
        fill_din('0);
    endtask

    task automatic test_shift();
        bit ok;
        fill_din('0);
        din_R_add[0] = 23'd1024;
        din_R_add[1] = 23'h7FFC00;
        din_R_sub[0] = 23'd1228800;
        mnext_add = 5'd11;
        mnext_sub = 5'd0;
        send_and_wait(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL shift_timeout: no valid_out");
        end
        checks++;
        if (dout_R_add[0] !== 11'd512) begin
            errors++;
            $display("FAIL shift_pos: got=%0d req 512", dout_R_add[0]);
        end
        checks++;
        if (dout_R_add[1] !== 11'h600) begin
            errors++;
            $display("FAIL shift_neg: got=%h req 600", dout_R_add[1]);
        end
        checks++;
        if (dout_R_sub[0] !== 11'd300 || dout_R_add[2] !== '0) begin
            errors++;
            $display("FAIL shift_min0: sub=%0d add2=%0d req 300/0",
                     dout_R_sub[0], dout_R_add[2]);
        end
        checks++;
        if (index_add !== 5'd11 || index_sub !== 5'd0) begin
            errors++;
            $display("FAIL shift_index: a=%0d s=%0d req 11/0",
                     index_add, index_sub);
        end
    endtask

    task automatic test_zero();
        bit ok;
        int nz;
        fill_din('0);
        mnext_add = 5'd31;
        mnext_sub = 5'd31;
        send_and_wait(ok);
        nz = 0;
        for (int i = 0; i < 8; i++) begin
            if (dout_R_add[i] !== '0) nz++;
            if (dout_Q_add[i] !== '0) nz++;
            if (dout_R_sub[i] !== '0) nz++;
            if (dout_Q_sub[i] !== '0) nz++;
        end
        checks++;
        if (!ok || nz != 0) begin
            errors++;
            $display("FAIL zero_data: ok=%b nonzero=%0d req 1/0", ok, nz);
        end
        checks++;
        if (index_add !== 5'd22 || index_sub !== 5'd22) begin
            errors++;
            $display("FAIL zero_clamp: a=%0d s=%0d req 22/22",
                     index_add, index_sub);
        end
    endtask

    task automatic test_round();
        bit ok;
        logic [10:0] exp_v;
`ifdef CBFP1_ROUND_EN
        exp_v = 11'd1;
`else
        exp_v = 11'd0;
`endif
        fill_din(23'd1);
        mnext_add = 5'd11;
        mnext_sub = 5'd11;
        send_and_wait(ok);
        checks++;
        if (!ok || dout_R_add[0] !== exp_v || dout_Q_sub[7] !== exp_v) begin
            errors++;
            $display("FAIL round: ok=%b ra=%0d qs=%0d req %0d",
                     ok, dout_R_add[0], dout_Q_sub[7], exp_v);
        end
    endtask

    task automatic test_sat();
        bit ok;
        fill_din(23'h3FFFFF);
        mnext_add = 5'd0;
        mnext_sub = 5'd0;
        send_and_wait(ok);
        checks++;
        if (!ok || dout_R_add[3] !== 11'd1023 ||
            dout_Q_sub[0] !== 11'd1023) begin
            errors++;
            $display("FAIL sat: ok=%b ra=%0d qs=%0d req 1023",
                     ok, dout_R_add[3], dout_Q_sub[0]);
        end
        fill_din('0);
    endtask

    task automatic test_stream();
        int sent;
        int rcv;
        bit prev_en;
        bit exp_fl;
        fill_din('0);
        mnext_add = '0;
        mnext_sub = '0;
        do_reset();
        sent = 0;
        rcv = 0;
        prev_en = 1'b1;
        for (int cyc = 0; cyc < 3000 && rcv < 70; cyc++) begin
            @(negedge clk);
            if (prev_en && valid_out) begin
                exp_fl = (rcv == 31 || rcv == 63);
                checks++;
                if (dout_R_add[0] !== 11'(rcv) || frame_last !== exp_fl) begin
                    errors++;
                    $display("FAIL stream_blk%0d: d=%0d fl=%b req %0d/%b",
                             rcv, dout_R_add[0], frame_last, rcv, exp_fl);
                end
                rcv++;
            end
            en = 1'($urandom_range(0, 1));
            if (en && sent < 70 && $urandom_range(0, 3) != 0) begin
                valid_in = 1'b1;
                din_R_add[0] = 23'(sent) << 12;
                sent++;
            end else begin
                valid_in = 1'b0;
            end
            prev_en = en;
        end
        en = 1'b1;
        valid_in = 1'b0;
        checks++;
        if (rcv != 70) begin
            errors++;
            $display("FAIL stream_count: got=%0d req 70", rcv);
        end
        checks++;
        if (dut.blk_cnt !== 5'd6) begin
            errors++;
            $display("FAIL stream_counter: got=%0d req 6", dut.blk_cnt);
        end
    endtask

    initial begin
        fill_din('0);
        test_reset();
        test_shift();
        test_zero();
        test_round();
        test_sat();
        test_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
